countup_timer: RTL and testbench

Up-counting interval timer with a programmable terminal value, one-shot or periodic mode, count enable, and a registered terminal-count strobe. It is the up-counting counterpart of the team's wrapping 3-bit down counter. It generates timing events and periodic ticks for the lab designs that consume strobes instead of decrementing values. It sits between a control source (start/stop/mode) and any block that needs a one-cycle tick every `limit+1` enabled cycles.

---
 rtl/countup_timer_pkg.sv | 12 +
 rtl/countup_timer_sat_inc.sv | 36 +++
 rtl/countup_timer.sv | 126 ++++++++++++
 tb/tb_countup_timer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/countup_timer_pkg.sv
// Shared types and defaults for the up-counting interval timer.
package countup_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WRAP_W_DEF = 8;

endpackage

// File: rtl/countup_timer_sat_inc.sv
// Saturating incrementer with synchronous clear; holds at all-ones.
module sat_inc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // next value: clear wins over increment, increment stops at all-ones
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    // value register
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/countup_timer.sv
// Up-counting interval timer: programmable terminal value, one-shot or
// periodic mode, registered terminal-count strobe and a saturating count
// of periodic reloads.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; count held at 0
// RUN   | counting enabled cycles toward the latched limit
// DONE  | one-shot finished; count holds the latched limit
module countup_timer
    import countup_timer_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic              stop,
    input  logic              periodic,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              tc,
    output logic [WRAP_W-1:0] wraps
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   lim_q,   lim_d;
    logic               per_q,   per_d;
    logic               tc_q,    tc_d;
    logic               wraps_clr;
    logic               wraps_inc;

    // next-state and datapath: stop beats terminal, terminal beats increment.
    // The terminal compare comes before the increment, so a full-range limit
    // never overflows count.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        lim_d     = lim_q;
        per_d     = per_q;
        tc_d      = 1'b0;
        wraps_clr = 1'b0;
        wraps_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (!stop && start) begin
                    state_d   = RUN;
                    lim_d     = limit;
                    per_d     = periodic;
                    wraps_clr = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (en && (count_q == lim_q)) begin
                    tc_d = 1'b1;
                    if (per_q) begin
                        count_d   = '0;
                        wraps_inc = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else if (en) begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (start) begin
                    state_d   = RUN;
                    count_d   = '0;
                    lim_d     = limit;
                    per_d     = periodic;
                    wraps_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // state, count, latched configuration and strobe registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            lim_q   <= '0;
            per_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lim_q   <= lim_d;
            per_q   <= per_d;
            tc_q    <= tc_d;
        end
    end

    sat_inc #(
        .W (WRAP_W)
    ) u_wraps (
        .clk   (clk),
        .reset (reset),
        .clr   (wraps_clr),
        .inc   (wraps_inc),
        .q     (wraps)
    );

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign tc    = tc_q;

endmodule

// File: tb/tb_countup_timer.sv
// Directed bench for countup_timer. Each stimulus step pushes the hand-computed
// post-edge outputs onto a queue; a monitor pops one entry after every edge and
// compares it against two instances (8-bit and 2-bit wrap counters).
module tb_countup_timer;

    typedef struct {
        int         id;
        logic [2:0] cnt;
        logic       busy;
        logic       done;
        logic       tc;
        int         wraps;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [2:0] limit;

    logic [2:0] count_a, count_b;
    logic       busy_a, busy_b, done_a, done_b, tc_a, tc_b;
    logic [7:0] wraps_a;
    logic [1:0] wraps_b;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    countup_timer #(.WIDTH(3), .WRAP_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
        .periodic(periodic), .limit(limit), .count(count_a), .busy(busy_a),
        .done(done_a), .tc(tc_a), .wraps(wraps_a)
    );

    countup_timer #(.WIDTH(3), .WRAP_W(2)) dut_b (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
        .periodic(periodic), .limit(limit), .count(count_b), .busy(busy_b),
        .done(done_b), .tc(tc_b), .wraps(wraps_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input int id, input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL vec%0d %s: got %0d expected %0d", id, name, got, want);
        end
    endtask

    // monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.id, "count",   int'(count_a), int'(e.cnt));
                chk(e.id, "busy",    int'(busy_a),  int'(e.busy));
                chk(e.id, "done",    int'(done_a),  int'(e.done));
                chk(e.id, "tc",      int'(tc_a),    int'(e.tc));
                chk(e.id, "wraps",   int'(wraps_a), e.wraps);
                chk(e.id, "wraps_w2", int'(wraps_b), (e.wraps > 3) ? 3 : e.wraps);
                chk(e.id, "count_w2", int'(count_b), int'(e.cnt));
                chk(e.id, "tc_w2",    int'(tc_b),    int'(e.tc));
            end
        end
    end

    // drive one cycle of inputs and record the outputs expected after the edge
    task automatic step(input logic r, input logic st, input logic sp, input logic e,
                        input logic p, input logic [2:0] lim,
                        input logic [2:0] c, input logic b, input logic d,
                        input logic t, input int w);
        exp_t x;
        @(negedge clk);
        reset    = r;
        start    = st;
        stop     = sp;
        en       = e;
        periodic = p;
        limit    = lim;
        x.id = vec_id; x.cnt = c; x.busy = b; x.done = d; x.tc = t; x.wraps = w;
        exp_q.push_back(x);
        vec_id++;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0;
        periodic = 1'b0; limit = 3'd0;

        //   r  st sp en p  lim     cnt b  d  tc wraps
        step(1, 0, 0, 0, 0, 3'd0,   0, 0, 0, 0, 0);

        // reset in the middle of a periodic run
        step(0, 1, 0, 1, 1, 3'd5,   0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 3'd5,   1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 3'd5,   2, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 3'd5,   3, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 3'd5,   0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 3'd0,   0, 0, 0, 0, 0);

        // periodic, limit 3; start and limit change mid-run are ignored
        step(0, 1, 0, 1, 1, 3'd3,   0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 3'd3,   1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 3'd3,   2, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 3'd3,   3, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 3'd3,   0, 1, 0, 1, 1);
        step(0, 1, 0, 1, 0, 3'd1,   1, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 3'd1,   2, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 3'd1,   3, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 3'd1,   0, 1, 0, 1, 2);
        step(0, 0, 0, 1, 0, 3'd1,   1, 1, 0, 0, 2);
        step(0, 0, 0, 0, 0, 3'd1,   1, 1, 0, 0, 2);
        step(0, 0, 1, 1, 1, 3'd3,   0, 0, 0, 0, 2);

        // start together with stop in IDLE stays in IDLE
        step(0, 1, 1, 1, 0, 3'd6,   0, 0, 0, 0, 2);
        step(0, 0, 0, 1, 0, 3'd6,   0, 0, 0, 0, 2);

        // one-shot, limit 7, enable every other cycle
        step(0, 1, 0, 0, 0, 3'd7,   0, 1, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            step(0, 0, 0, 1, 0, 3'd7,   3'(i), 1, 0, 0, 0);
            step(0, 0, 0, 0, 0, 3'd7,   3'(i), 1, 0, 0, 0);
        end
        step(0, 0, 0, 1, 0, 3'd7,   7, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 3'd7,   7, 0, 1, 0, 0);

        // restart from DONE, then stop on the terminal cycle
        step(0, 1, 0, 1, 0, 3'd2,   0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 3'd2,   1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 3'd2,   2, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 3'd2,   0, 0, 0, 0, 0);

        // limit 0 periodic: tc every enabled cycle, 2-bit wraps saturates at 3
        step(0, 1, 0, 1, 1, 3'd0,   0, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 0, 1, 1, 3'd0,   0, 1, 0, 1, i);
        end
        step(0, 0, 0, 0, 1, 3'd0,   0, 1, 0, 0, 6);
        step(0, 0, 1, 0, 1, 3'd0,   0, 0, 0, 0, 6);

        // limit 0 one-shot, then start+stop in DONE
        step(0, 1, 0, 0, 0, 3'd0,   0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 3'd0,   0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 3'd0,   0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0, 3'd0,   0, 0, 0, 0, 0);

        // full-range periodic, limit 7
        step(0, 1, 0, 1, 1, 3'd7,   0, 1, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            step(0, 0, 0, 1, 1, 3'd7,   3'(i), 1, 0, 0, 0);
        end
        step(0, 0, 0, 1, 1, 3'd7,   0, 1, 0, 1, 1);
        step(0, 0, 1, 1, 1, 3'd7,   0, 0, 0, 0, 1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
